// File: rtl/jvs_pkg.sv
// Shared JVS framing constants, deframer state encoding and error codes.
package jvs_pkg;

    localparam logic [7:0] JVS_SYNC  = 8'hE0;
    localparam logic [7:0] JVS_ESC   = 8'hD0;
    localparam logic [7:0] JVS_BCAST = 8'hFF;

    typedef enum logic [2:0] {
        S_HUNT = 3'd0,
        S_NODE = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_SUM  = 3'd4,
        S_EMIT = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_CSUM   = 3'd1,
        ERR_LEN    = 3'd2,
        ERR_RESYNC = 3'd3,
        ERR_ESC    = 3'd4
    } err_code_e;

endpackage

// File: rtl/jvs_payload_ram.sv
// Simple dual-port payload buffer: one write port, one registered read port.
// Read data appears the cycle after re and holds until the next re; no reset.
module jvs_payload_ram #(
    parameter int DEPTH = 253,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/jvs_rx_deframer.sv
// JVS RX deframer: unescape, length/checksum check, node filter, buffered payload release.
// First payload beat 2 cycles after the SUM byte; RX is stalled (o_ready=0) while the payload streams.
module jvs_rx_deframer
    import jvs_pkg::*;
#(
    parameter int MAX_PAYLOAD = 253,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [7:0]       i_data,
    output logic             o_ready,
    input  logic [7:0]       i_node_addr,
    input  logic             i_promisc,
    output logic             o_valid,
    output logic [7:0]       o_data,
    output logic             o_last,
    input  logic             i_ready,
    output logic [7:0]       o_node,
    output logic [7:0]       o_len,
    output logic             o_pkt_ok,
    output logic             o_err,
    output logic [2:0]       o_err_code,
    output logic [CNT_W-1:0] o_pkt_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam int         AW       = $clog2(MAX_PAYLOAD);
    localparam logic [8:0] MAX_LEN9 = 9'(MAX_PAYLOAD);

    state_e     state, state_next;
    err_code_e  err_code_next;
    logic       err_set, pkt_ok_set;
    logic       esc;
    logic [7:0] node, sum, cnt, idx, rd_ptr;
    logic [7:0] val, ram_q;
    logic [8:0] len_m1;
    logic       take, is_sync, is_esc, byte_ok, addr_match;
    logic       fire, load;

    assign o_ready    = (state != S_EMIT);
    assign take       = i_valid & o_ready;
    assign is_sync    = (i_data == JVS_SYNC);
    assign is_esc     = (i_data == JVS_ESC);
    assign val        = esc ? i_data + 8'd1 : i_data;
    assign len_m1     = {1'b0, val} - 9'd1;
    assign byte_ok    = take & ~is_sync & ~is_esc & (state != S_HUNT);
    assign addr_match = i_promisc | (node == i_node_addr) | (node == JVS_BCAST);

    // Emit pipeline: a read is issued whenever the output register is free or draining.
    assign fire   = o_valid & i_ready;
    assign load   = (state == S_EMIT) & (~o_valid | fire) & (rd_ptr < cnt);
    assign o_data = o_valid ? ram_q : 8'h00;

    always_comb begin
        state_next    = state;
        err_set       = 1'b0;
        err_code_next = ERR_NONE;
        pkt_ok_set    = 1'b0;
        case (state)
            S_HUNT: begin
                if (take && is_sync)
                    state_next = S_NODE;
            end
            S_NODE, S_LEN, S_DATA, S_SUM: begin
                if (take && is_sync) begin
                    err_set       = 1'b1;
                    err_code_next = esc ? ERR_ESC : ERR_RESYNC;
                    state_next    = S_NODE;
                end else if (byte_ok) begin
                    case (state)
                        S_NODE: state_next = S_LEN;
                        S_LEN: begin
                            if (val == 8'd0 || len_m1 > MAX_LEN9) begin
                                err_set       = 1'b1;
                                err_code_next = ERR_LEN;
                                state_next    = S_HUNT;
                            end else if (val == 8'd1) begin
                                state_next = S_SUM;
                            end else begin
                                state_next = S_DATA;
                            end
                        end
                        S_DATA: begin
                            if (idx + 8'd1 == cnt)
                                state_next = S_SUM;
                        end
                        default: begin
                            if (!addr_match) begin
                                state_next = S_HUNT;
                            end else if (val != sum) begin
                                err_set       = 1'b1;
                                err_code_next = ERR_CSUM;
                                state_next    = S_HUNT;
                            end else begin
                                pkt_ok_set = 1'b1;
                                state_next = (cnt == 8'd0) ? S_HUNT : S_EMIT;
                            end
                        end
                    endcase
                end
            end
            S_EMIT: begin
                if (fire && o_last)
                    state_next = S_HUNT;
            end
            default: state_next = S_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_HUNT;
            esc        <= 1'b0;
            node       <= 8'h00;
            sum        <= 8'h00;
            cnt        <= 8'h00;
            idx        <= 8'h00;
            rd_ptr     <= 8'h00;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_pkt_ok   <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= 3'd0;
            o_node     <= 8'h00;
            o_len      <= 8'h00;
            o_pkt_cnt  <= '0;
            o_err_cnt  <= '0;
        end else begin
            state    <= state_next;
            o_pkt_ok <= pkt_ok_set;
            o_err    <= err_set;
            if (take)
                esc <= is_esc & (state != S_HUNT);
            if (byte_ok) begin
                case (state)
                    S_NODE: begin
                        node <= val;
                        sum  <= val;
                    end
                    S_LEN: begin
                        sum    <= sum + val;
                        cnt    <= val - 8'd1;
                        idx    <= 8'h00;
                        rd_ptr <= 8'h00;
                    end
                    S_DATA: begin
                        sum <= sum + val;
                        idx <= idx + 8'd1;
                    end
                    default: ;
                endcase
            end
            if (err_set) begin
                o_err_code <= err_code_next;
                if (o_err_cnt != {CNT_W{1'b1}})
                    o_err_cnt <= o_err_cnt + CNT_W'(1);
            end
            if (pkt_ok_set) begin
                o_node <= node;
                o_len  <= cnt;
                if (o_pkt_cnt != {CNT_W{1'b1}})
                    o_pkt_cnt <= o_pkt_cnt + CNT_W'(1);
            end
            if (load) begin
                o_valid <= 1'b1;
                o_last  <= (rd_ptr == cnt - 8'd1);
                rd_ptr  <= rd_ptr + 8'd1;
            end else if (fire) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end

    jvs_payload_ram #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (byte_ok && state == S_DATA),
        .waddr (idx[AW-1:0]),
        .wdata (val),
        .re    (load),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_jvs_rx_deframer.sv
// Directed scoreboard bench for jvs_rx_deframer: expected beats/events are queued
// at stimulus time and a negedge monitor pops and compares them.
module tb_jvs_rx_deframer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        o_ready;
    logic [7:0]  i_node_addr;
    logic        i_promisc;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_last;
    logic        i_ready;
    logic [7:0]  o_node;
    logic [7:0]  o_len;
    logic        o_pkt_ok;
    logic        o_err;
    logic [2:0]  o_err_code;
    logic [15:0] o_pkt_cnt;
    logic [15:0] o_err_cnt;

    jvs_rx_deframer dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .i_node_addr (i_node_addr),
        .i_promisc   (i_promisc),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_last      (o_last),
        .i_ready     (i_ready),
        .o_node      (o_node),
        .o_len       (o_len),
        .o_pkt_ok    (o_pkt_ok),
        .o_err       (o_err),
        .o_err_code  (o_err_code),
        .o_pkt_cnt   (o_pkt_cnt),
        .o_err_cnt   (o_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct packed {
        logic       ok;
        logic [2:0] code;
        logic [7:0] node;
        logic [7:0] len;
    } ev_t;

    beat_t      exp_beats[$];
    ev_t        exp_evs[$];
    logic [7:0] pkt[$];
    int         checks   = 0;
    int         failures = 0;
    beat_t      mb;
    ev_t        me;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic exp_ok(input logic [7:0] node, input logic [7:0] len);
        exp_evs.push_back('{ok: 1'b1, code: 3'd0, node: node, len: len});
    endtask

    task automatic exp_err(input logic [2:0] code);
        exp_evs.push_back('{ok: 1'b0, code: code, node: 8'h00, len: 8'h00});
    endtask

    task automatic exp_beat(input logic [7:0] d, input logic l);
        exp_beats.push_back('{d: d, l: l});
    endtask

    // Monitor: every presented beat or pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid && i_ready) begin
                if (exp_beats.size() == 0) begin
                    flag($sformatf("unexpected_beat data=%0h last=%0b", o_data, o_last));
                end else begin
                    mb = exp_beats.pop_front();
                    check("beat_data", 32'(o_data), 32'(mb.d));
                    check("beat_last", 32'(o_last), 32'(mb.l));
                end
            end
            if (o_pkt_ok || o_err) begin
                if (exp_evs.size() == 0) begin
                    flag($sformatf("unexpected_event ok=%0b err=%0b code=%0d", o_pkt_ok, o_err, o_err_code));
                end else begin
                    me = exp_evs.pop_front();
                    check("event_is_ok", 32'(o_pkt_ok), 32'(me.ok));
                    check("event_is_err", 32'(o_err), 32'(!me.ok));
                    if (me.ok) begin
                        check("pkt_node", 32'(o_node), 32'(me.node));
                        check("pkt_len", 32'(o_len), 32'(me.len));
                    end else begin
                        check("err_code", 32'(o_err_code), 32'(me.code));
                    end
                end
            end
        end
    end

    task automatic send_pkt();
        foreach (pkt[k]) begin
            int n;
            n       = 0;
            i_valid = 1'b1;
            i_data  = pkt[k];
            @(negedge clk);
            while (!o_ready && n < 200) begin
                n++;
                @(negedge clk);
            end
            if (!o_ready)
                flag($sformatf("send_timeout byte=%0h", pkt[k]));
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(o_ready && !o_valid && exp_beats.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300)
            flag($sformatf("drain_timeout beats_left=%0d", exp_beats.size()));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int    n;
        int    bad;
        logic [7:0] held;
        rst         = 1'b1;
        i_valid     = 1'b0;
        i_data      = 8'h00;
        i_node_addr = 8'h01;
        i_promisc   = 1'b0;
        i_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_ready", 32'(o_ready), 32'd1);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_last", 32'(o_last), 32'd0);
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_pulses", 32'({o_pkt_ok, o_err}), 32'd0);
        check("rst_node_len", 32'({o_node, o_len, 5'd0, o_err_code}), 32'd0);
        check("rst_counters", 32'({o_pkt_cnt, o_err_cnt}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Normal packet, also checks first-beat latency.
        exp_ok(8'h01, 8'd2);
        exp_beat(8'h10, 1'b0);
        exp_beat(8'h20, 1'b1);
        pkt = '{8'hE0, 8'h01, 8'h03, 8'h10, 8'h20, 8'h34};
        send_pkt();
        @(negedge clk);
        check("latency_cycle1_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        check("latency_cycle2_valid", 32'(o_valid), 32'd1);
        wait_drain();
        check("pkt_cnt_after_normal", 32'(o_pkt_cnt), 32'd1);

        // Escapes
        exp_ok(8'h01, 8'd1);
        exp_beat(8'hE0, 1'b1);
        pkt = '{8'hE0, 8'h01, 8'h02, 8'hD0, 8'hDF, 8'hE3};
        send_pkt();
        wait_drain();
        exp_ok(8'h01, 8'd1);
        exp_beat(8'hD0, 1'b1);
        pkt = '{8'hE0, 8'h01, 8'h02, 8'hD0, 8'hCF, 8'hD3};
        send_pkt();
        wait_drain();

        // Bad checksum
        exp_err(3'd1);
        pkt = '{8'hE0, 8'h01, 8'h02, 8'h55, 8'h00};
        send_pkt();
        wait_drain();
        check("err_cnt_after_csum", 32'(o_err_cnt), 32'd1);

        // Resync, then resync after a dangling escape
        exp_err(3'd3);
        exp_ok(8'h01, 8'd1);
        exp_beat(8'hAA, 1'b1);
        pkt = '{8'hE0, 8'h01, 8'h05, 8'h11, 8'hE0, 8'h01, 8'h02, 8'hAA, 8'hAD};
        send_pkt();
        wait_drain();
        exp_err(3'd4);
        exp_ok(8'h01, 8'd1);
        exp_beat(8'hAA, 1'b1);
        pkt = '{8'hE0, 8'h01, 8'h05, 8'h11, 8'hD0, 8'hE0, 8'h01, 8'h02, 8'hAA, 8'hAD};
        send_pkt();
        wait_drain();

        // Length errors
        exp_err(3'd2);
        pkt = '{8'hE0, 8'h01, 8'h00};
        send_pkt();
        wait_drain();
        exp_err(3'd2);
        pkt = '{8'hE0, 8'h01, 8'hFF, 8'h00, 8'h00};
        send_pkt();
        wait_drain();

        // Node filter: foreign node dropped silently, broadcast accepted
        i_node_addr = 8'h02;
        pkt = '{8'hE0, 8'h01, 8'h03, 8'h10, 8'h20, 8'h34};
        send_pkt();
        wait_drain();
        check("pkt_cnt_after_filter", 32'(o_pkt_cnt), 32'd5);
        exp_ok(8'hFF, 8'd2);
        exp_beat(8'h10, 1'b0);
        exp_beat(8'h20, 1'b1);
        pkt = '{8'hE0, 8'hFF, 8'h03, 8'h10, 8'h20, 8'h32};
        send_pkt();
        wait_drain();
        i_node_addr = 8'h01;

        // Backpressure: stall 10 cycles with A3 on the output
        exp_ok(8'h01, 8'd4);
        exp_beat(8'hA1, 1'b0);
        exp_beat(8'hA2, 1'b0);
        exp_beat(8'hA3, 1'b0);
        exp_beat(8'hA4, 1'b1);
        pkt = '{8'hE0, 8'h01, 8'h05, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h90};
        send_pkt();
        n = 0;
        @(negedge clk);
        while (!(o_valid && o_data == 8'hA2) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50)
            flag("bp_wait_A2_timeout");
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        bad = 0;
        @(negedge clk);
        held = o_data;
        check("bp_held_data", 32'(held), 32'hA3);
        for (int c = 0; c < 10; c++) begin
            if (!(o_valid && o_data == held && !o_last && !o_ready))
                bad++;
            @(negedge clk);
        end
        check("bp_unstable_cycles", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        wait_drain();

        // Asynchronous reset in the middle of EMIT
        exp_ok(8'h01, 8'd4);
        exp_beat(8'hA1, 1'b0);
        exp_beat(8'hA2, 1'b0);
        exp_beat(8'hA3, 1'b0);
        exp_beat(8'hA4, 1'b1);
        send_pkt();
        n = 0;
        @(negedge clk);
        while (!o_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50)
            flag("emit_wait_timeout");
        check("pkt_cnt_before_reset", 32'(o_pkt_cnt), 32'd8);
        check("err_cnt_before_reset", 32'(o_err_cnt), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_o_valid", 32'(o_valid), 32'd0);
        check("arst_o_ready", 32'(o_ready), 32'd1);
        check("arst_counters", 32'({o_pkt_cnt, o_err_cnt}), 32'd0);
        exp_beats.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_idle_valid", 32'(o_valid), 32'd0);
        check("beats_left", 32'(exp_beats.size()), 32'd0);
        check("events_left", 32'(exp_evs.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
